// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB stage bundle: EX/MEM buffer outputs in, register-file write port and stall/fault out.
// master = upstream pipeline side, slave = mem_wb_stage.
interface mem_wb_stage_if;
  logic [15:0] ALUResult_MEM;
  logic [15:0] R0D_MEM;
  logic [15:0] DataIn_MEM;
  logic [3:0]  RA1_MEM;
  logic [3:0]  opcode_MEM;
  logic [3:0]  FN_Offset_MEM;
  logic        regWrite_MEM;
  logic        r0Write_MEM;
  logic        memRead_MEM;
  logic        memWrite_MEM;
  logic        memSource_MEM;

  logic [3:0]  WA1;
  logic [15:0] WD1;
  logic [15:0] R0D;
  logic        RegWrite_WB;
  logic        R0W_WB;
  logic [3:0]  opcode_WB;
  logic        mem_stall;
  logic        mem_fault;

  modport master (
    output ALUResult_MEM, R0D_MEM, DataIn_MEM, RA1_MEM, opcode_MEM, FN_Offset_MEM,
           regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM,
    input  WA1, WD1, R0D, RegWrite_WB, R0W_WB, opcode_WB, mem_stall, mem_fault
  );

  modport slave (
    input  ALUResult_MEM, R0D_MEM, DataIn_MEM, RA1_MEM, opcode_MEM, FN_Offset_MEM,
           regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM,
    output WA1, WD1, R0D, RegWrite_WB, R0W_WB, opcode_WB, mem_stall, mem_fault
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: multi-cycle word memory with stall generation,
// sticky misalignment flag and the MEM/WB pipeline register driving the register-file write port.
module mem_wb_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);
  localparam int         DATA_W   = 16;
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam bit         MULTI    = (MEM_LATENCY > 1);
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 2);

  typedef enum logic { IDLE, BUSY } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [ADDR_BITS-1:0]  idx;
  logic                  is_mem;
  logic                  misaligned;
  logic                  access;
  logic                  stall;
  logic                  complete;
  logic                  both_rw;
  logic [DATA_W-1:0]     memword;
  logic                  unused_fn;

  assign idx        = bus.ALUResult_MEM[ADDR_BITS:1];
  assign is_mem     = bus.memRead_MEM | bus.memWrite_MEM;
  assign misaligned = is_mem & bus.ALUResult_MEM[0];
  assign access     = is_mem & ~bus.ALUResult_MEM[0];
  assign both_rw    = bus.memRead_MEM & bus.memWrite_MEM;
  assign memword    = mem[idx];
  assign unused_fn  = ^bus.FN_Offset_MEM;

  // Inputs are held while stalled, so access stays asserted through BUSY.
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) stall = access & MULTI;
    else               stall = (cnt != 4'd0);
  end

  assign complete      = access & ~stall;
  assign bus.mem_stall = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (access && MULTI) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
        BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
              else             state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset wins over a completing store, so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && bus.memWrite_MEM) begin
      mem[idx] <= bus.DataIn_MEM;
    end
  end

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.WA1         <= '0;
      bus.WD1         <= '0;
      bus.R0D         <= '0;
      bus.RegWrite_WB <= 1'b0;
      bus.R0W_WB      <= 1'b0;
      bus.opcode_WB   <= '0;
      bus.mem_fault   <= 1'b0;
    end else begin
      if (stall) begin
        bus.WA1         <= '0;
        bus.WD1         <= '0;
        bus.R0D         <= '0;
        bus.RegWrite_WB <= 1'b0;
        bus.R0W_WB      <= 1'b0;
        bus.opcode_WB   <= '0;
      end else begin
        bus.WA1         <= bus.RA1_MEM;
        bus.WD1         <= bus.memSource_MEM ? memword : bus.ALUResult_MEM;
        bus.R0D         <= bus.R0D_MEM;
        bus.RegWrite_WB <= bus.regWrite_MEM & ~misaligned & ~both_rw;
        bus.R0W_WB      <= bus.r0Write_MEM & ~misaligned;
        bus.opcode_WB   <= bus.opcode_MEM;
      end
      if (misaligned && !stall) bus.mem_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: one instance at latency 2, one at latency 4.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_wb_stage_if bus_a ();
  mem_wb_stage_if bus_b ();

  mem_wb_stage #(.ADDR_BITS(8), .MEM_LATENCY(2)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  mem_wb_stage #(.ADDR_BITS(8), .MEM_LATENCY(4)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  logic        sel = 1'b0;
  logic [15:0] s_alu = '0, s_r0d = '0, s_din = '0;
  logic [3:0]  s_ra1 = '0, s_opc = '0, s_fn = '0;
  logic        s_rw = 1'b0, s_r0w = 1'b0, s_mr = 1'b0, s_mw = 1'b0, s_ms = 1'b0;

  always_comb begin
    bus_a.ALUResult_MEM = sel ? 16'h0 : s_alu;
    bus_a.R0D_MEM       = sel ? 16'h0 : s_r0d;
    bus_a.DataIn_MEM    = sel ? 16'h0 : s_din;
    bus_a.RA1_MEM       = sel ? 4'h0  : s_ra1;
    bus_a.opcode_MEM    = sel ? 4'h0  : s_opc;
    bus_a.FN_Offset_MEM = sel ? 4'h0  : s_fn;
    bus_a.regWrite_MEM  = sel ? 1'b0  : s_rw;
    bus_a.r0Write_MEM   = sel ? 1'b0  : s_r0w;
    bus_a.memRead_MEM   = sel ? 1'b0  : s_mr;
    bus_a.memWrite_MEM  = sel ? 1'b0  : s_mw;
    bus_a.memSource_MEM = sel ? 1'b0  : s_ms;
    bus_b.ALUResult_MEM = sel ? s_alu : 16'h0;
    bus_b.R0D_MEM       = sel ? s_r0d : 16'h0;
    bus_b.DataIn_MEM    = sel ? s_din : 16'h0;
    bus_b.RA1_MEM       = sel ? s_ra1 : 4'h0;
    bus_b.opcode_MEM    = sel ? s_opc : 4'h0;
    bus_b.FN_Offset_MEM = sel ? s_fn  : 4'h0;
    bus_b.regWrite_MEM  = sel ? s_rw  : 1'b0;
    bus_b.r0Write_MEM   = sel ? s_r0w : 1'b0;
    bus_b.memRead_MEM   = sel ? s_mr  : 1'b0;
    bus_b.memWrite_MEM  = sel ? s_mw  : 1'b0;
    bus_b.memSource_MEM = sel ? s_ms  : 1'b0;
  end

  logic [3:0]  o_wa, o_opc;
  logic [15:0] o_wd, o_r0d;
  logic        o_rw, o_r0w, o_stall, o_fault;
  assign o_wa    = sel ? bus_b.WA1         : bus_a.WA1;
  assign o_wd    = sel ? bus_b.WD1         : bus_a.WD1;
  assign o_r0d   = sel ? bus_b.R0D         : bus_a.R0D;
  assign o_rw    = sel ? bus_b.RegWrite_WB : bus_a.RegWrite_WB;
  assign o_r0w   = sel ? bus_b.R0W_WB      : bus_a.R0W_WB;
  assign o_opc   = sel ? bus_b.opcode_WB   : bus_a.opcode_WB;
  assign o_stall = sel ? bus_b.mem_stall   : bus_a.mem_stall;
  assign o_fault = sel ? bus_b.mem_fault   : bus_a.mem_fault;

  typedef struct {
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] r0d;
    logic        rw;
    logic        r0w;
    logic [3:0]  opc;
    bit          chk_wd;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic clear_stim();
    s_alu = '0; s_r0d = '0; s_din = '0; s_ra1 = '0; s_opc = '0; s_fn = '0;
    s_rw = 0; s_r0w = 0; s_mr = 0; s_mw = 0; s_ms = 0;
  endtask

  // Called just after a rising edge; returns just after the instruction's WB edge.
  task automatic issue(input string name, input logic [3:0] ra1, input logic [15:0] alu,
                       input logic [15:0] din, input logic [15:0] r0d, input logic [3:0] opc,
                       input logic rw, input logic r0w, input logic mr, input logic mw,
                       input logic ms, input logic [15:0] exp_wd, input bit chk_wd,
                       input logic exp_rw, input logic exp_r0w, input int exp_stalls);
    exp_t e;
    int   stalls;
    bit   done;
    s_ra1 = ra1; s_alu = alu; s_din = din; s_r0d = r0d; s_opc = opc; s_fn = 4'hA;
    s_rw = rw; s_r0w = r0w; s_mr = mr; s_mw = mw; s_ms = ms;
    e.wa = ra1; e.wd = exp_wd; e.r0d = r0d; e.rw = exp_rw; e.r0w = exp_r0w;
    e.opc = opc; e.chk_wd = chk_wd; e.stalls = exp_stalls;
    sb.push_back(e);
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge clk);
      if (o_stall) begin
        stalls++;
        @(posedge clk); #1;
        checks++;
        if (o_rw !== 1'b0 || o_r0w !== 1'b0 || o_opc !== 4'h0 || o_wd !== 16'h0) begin
          failures++;
          $display("FAIL %s bubble: rw=%b r0w=%b opc=%h wd=%h, required all 0", name, o_rw, o_r0w, o_opc, o_wd);
        end
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s stall_timeout: stall still high after 32 cycles, required release", name);
      sb.delete();
      clear_stim();
      return;
    end
    @(posedge clk); #1;
    clear_stim();
    e = sb.pop_front();
    checks++;
    if (stalls !== e.stalls) begin
      failures++; $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, e.stalls);
    end
    checks++;
    if (o_wa !== e.wa) begin
      failures++; $display("FAIL %s WA1: got %h, required %h", name, o_wa, e.wa);
    end
    if (e.chk_wd) begin
      checks++;
      if (o_wd !== e.wd) begin
        failures++; $display("FAIL %s WD1: got %h, required %h", name, o_wd, e.wd);
      end
    end
    checks++;
    if (o_r0d !== e.r0d) begin
      failures++; $display("FAIL %s R0D: got %h, required %h", name, o_r0d, e.r0d);
    end
    checks++;
    if (o_rw !== e.rw || o_r0w !== e.r0w) begin
      failures++; $display("FAIL %s enables: rw=%b r0w=%b, required rw=%b r0w=%b", name, o_rw, o_r0w, e.rw, e.r0w);
    end
    checks++;
    if (o_opc !== e.opc) begin
      failures++; $display("FAIL %s opcode_WB: got %h, required %h", name, o_opc, e.opc);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      checks++;
      if (o_wa !== 4'h0 || o_wd !== 16'h0 || o_r0d !== 16'h0 || o_rw !== 1'b0 ||
          o_r0w !== 1'b0 || o_opc !== 4'h0 || o_stall !== 1'b0 || o_fault !== 1'b0) begin
        failures++;
        $display("FAIL %s dut%0d: wa=%h wd=%h r0d=%h rw=%b r0w=%b opc=%h stall=%b fault=%b, required all 0",
                 name, s, o_wa, o_wd, o_r0d, o_rw, o_r0w, o_opc, o_stall, o_fault);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    clear_stim();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
  endtask

  task automatic test_alu();
    issue("alu_1234", 4'd5, 16'h1234, 16'h0, 16'h0, 4'h1, 1, 0, 0, 0, 0, 16'h1234, 1, 1, 0, 0);
    issue("alu_r0", 4'd2, 16'h00FF, 16'h0, 16'hCAFE, 4'h6, 1, 1, 0, 0, 0, 16'h00FF, 1, 1, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [15:0] v;
      v = 16'h1000 * 16'(i + 1) + 16'h0021;
      issue("b2b_alu", 4'(i + 8), v, 16'h0, 16'(i), 4'(i + 2), 1, 0, 0, 0, 0, v, 1, 1, 0, 0);
    end
  endtask

  task automatic test_store_load_l2();
    issue("store_beef", 4'd0, 16'h0010, 16'hBEEF, 16'h0, 4'h9, 0, 0, 0, 1, 0, 16'h0010, 1, 0, 0, 1);
    issue("load_beef", 4'd3, 16'h0010, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'hBEEF, 1, 1, 0, 1);
    issue("rdwr_is_store", 4'd4, 16'h0012, 16'h4242, 16'h0, 4'h8, 1, 0, 1, 1, 0, 16'h0012, 1, 0, 0, 1);
    issue("load_rdwr", 4'd4, 16'h0012, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h4242, 1, 1, 0, 1);
  endtask

  task automatic test_wrap();
    issue("store_7777", 4'd0, 16'h0202, 16'h7777, 16'h0, 4'h9, 0, 0, 0, 1, 0, 16'h0202, 1, 0, 0, 1);
    issue("load_wrap", 4'd6, 16'h0002, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h7777, 1, 1, 0, 1);
  endtask

  task automatic test_misaligned();
    checks++;
    if (o_fault !== 1'b0) begin
      failures++; $display("FAIL fault_before: got %b, required 0", o_fault);
    end
    issue("mis_load", 4'd7, 16'h0011, 16'h0, 16'h0, 4'h8, 1, 1, 1, 0, 1, 16'h0, 0, 0, 0, 0);
    checks++;
    if (o_fault !== 1'b1) begin
      failures++; $display("FAIL fault_set: got %b, required 1", o_fault);
    end
    issue("mis_store", 4'd1, 16'h0021, 16'h9999, 16'h0, 4'h9, 0, 0, 0, 1, 0, 16'h0021, 1, 0, 0, 0);
    issue("load_after_mis", 4'd1, 16'h0020, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 1);
    checks++;
    if (o_fault !== 1'b1) begin
      failures++; $display("FAIL fault_sticky: got %b, required 1", o_fault);
    end
  endtask

  task automatic test_reset_abort();
    issue("store_aaaa", 4'd0, 16'h0004, 16'hAAAA, 16'h0, 4'h9, 0, 0, 0, 1, 0, 16'h0004, 1, 0, 0, 1);
    s_alu = 16'h0004; s_din = 16'h5555; s_mw = 1'b1; s_opc = 4'h9;
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1) begin
      failures++; $display("FAIL abort_stall: got %b, required 1", o_stall);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    clear_stim();
    @(posedge clk); #1;
    check_idle_outputs("reset_abort");
    rst = 1'b0;
    issue("load_after_abort", 4'd2, 16'h0004, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 1);
    issue("load_cleared_beef", 4'd3, 16'h0010, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 1);
  endtask

  task automatic test_latency4();
    sel = 1'b1;
    issue("l4_load_unwritten", 4'd7, 16'h0030, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h0000, 1, 1, 0, 3);
    issue("l4_store", 4'd0, 16'h0030, 16'h3C3C, 16'h0, 4'h9, 0, 0, 0, 1, 0, 16'h0030, 1, 0, 0, 3);
    issue("l4_load", 4'd9, 16'h0030, 16'h0, 16'h0, 4'h8, 1, 0, 1, 0, 1, 16'h3C3C, 1, 1, 0, 3);
    issue("l4_alu", 4'd4, 16'h0ACE, 16'h0, 16'h0, 4'h2, 1, 0, 0, 0, 0, 16'h0ACE, 1, 1, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_store_load_l2();
    test_wrap();
    test_misaligned();
    test_reset_abort();
    test_latency4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage fed directly by the EX/MEM buffer outputs.
- Performs data-memory loads and stores with a configurable multi-cycle latency. Raises a stall while an access is outstanding.
- Registers the MEM/WB pipeline state and drives the register-file write port (WA1/WD1/R0D/RegWrite_WB/R0W_WB).

Parameters:
- ADDR_BITS, 8: word-index width; memory holds 2^ADDR_BITS 16-bit words.
- MEM_LATENCY, 2: cycles per load/store, legal range 1..15.

Ports:
- clk  in  1  stage clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUResult_MEM  in  16  byte address for load/store; writeback value for ALU ops.
- R0D_MEM  in  16  R0 result (multiply/divide high part), passed to writeback.
- DataIn_MEM  in  16  store data.
- RA1_MEM  in  4  destination register index.
- opcode_MEM  in  4  passed through to opcode_WB.
- FN_Offset_MEM  in  4  unused internally; accepted for interface symmetry.
- regWrite_MEM, r0Write_MEM, memRead_MEM, memWrite_MEM, memSource_MEM  in  1 each  control bits; memSource=1 selects load data for writeback.
- WA1  out  4  register-file write address.
- WD1  out  16  register-file write data.
- R0D  out  16  R0 write data.
- RegWrite_WB  out  1  register-file write enable.
- R0W_WB  out  1  R0 write enable.
- opcode_WB  out  4  opcode of the instruction in WB, for forwarding.
- mem_stall  out  1  combinational; high means upstream must hold EX/MEM contents.
- mem_fault  out  1  sticky misaligned-access flag.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, latency counter 0, every memory word cleared to 0. Reset during BUSY aborts the access; a pending store is never committed.
- Word index = ALUResult_MEM[ADDR_BITS:1]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_BITS+1).
- Access = (memRead_MEM | memWrite_MEM) & ~ALUResult_MEM[0].
- Misaligned (bit0=1 with memRead or memWrite):
  - No memory access and no stall.
  - mem_fault set at next edge and held until reset.
  - The instruction enters WB with RegWrite_WB=R0W_WB=0.
- Both memRead and memWrite set: treated as a store. RegWrite_WB forced 0 for that instruction.
- FSM states IDLE and BUSY, with a 4-bit counter cnt:
  - IDLE, access, MEM_LATENCY>1: mem_stall=1; next BUSY, cnt=MEM_LATENCY-2.
  - BUSY, cnt!=0: mem_stall=1; cnt decrements.
  - BUSY, cnt==0: mem_stall=0; the access completes at this edge; next IDLE.
  - MEM_LATENCY=1: FSM stays in IDLE; the access completes in its presentation cycle.
- Timing: an access presented in cycle t stalls cycles t..t+L-2 and completes on the edge ending cycle t+L-1.
- Input stability: inputs are held by upstream while mem_stall is high and are not re-checked during BUSY.
- Completion edge:
  - A store writes DataIn_MEM to mem[index].
  - A load's word is read from mem[index] and captured into WD1 when memSource_MEM=1.
- MEM/WB register, loaded every edge with mem_stall=0:
  - WA1←RA1_MEM
  - WD1←(memSource_MEM ? memword : ALUResult_MEM)
  - R0D←R0D_MEM
  - RegWrite_WB←regWrite_MEM
  - R0W_WB←r0Write_MEM
  - opcode_WB←opcode_MEM
- On edges with mem_stall=1, a bubble is loaded instead: RegWrite_WB=R0W_WB=0, opcode_WB=0, data fields 0.
- Non-memory instructions never stall and take exactly 1 cycle MEM→WB.
- A store followed in the next instruction by a load to the same address returns the stored value; the write commits before the load's completion edge.

Test Plan:
- Reset, then an ALU op with ALUResult_MEM=0x1234, RA1_MEM=5, regWrite_MEM=1 → next cycle WA1=5, WD1=0x1234, RegWrite_WB=1, mem_stall never high.
- L=2: store DataIn_MEM=0xBEEF to addr 0x0010, then load from 0x0010 with memSource=1, RA1=3 →
  - each access shows mem_stall high for exactly 1 cycle
  - a bubble (RegWrite_WB=0) occurs during each stall
  - after the load, WD1=0xBEEF, WA1=3.
- L=4: load from an unwritten address → mem_stall high for 3 consecutive cycles, then WD1=0x0000 with RegWrite_WB=1.
- Load from 0x0011 → no stall, mem_fault=1 from next cycle until reset, RegWrite_WB=0 for that instruction, memory unchanged.
- Store 0xAAAA to 0x0004; then in a separate access, store 0x5555 to 0x0004 with reset asserted during its first stall cycle → after reset, load 0x0004 reads 0x0000: memory was cleared and the aborted store never committed.
- With ADDR_BITS=8, store 0x7777 to 0x0202, load from 0x0002 → WD1=0x7777 (wrap-around).
